// File: rtl/alu_seq.sv
// alu_seq: registered ALU with start/done handshake and a sticky NZCV flag register.
// Single-cycle ops (ADD, SUB, AND, OR, XOR, SHL, SRA) complete one clock after start.
// MUL is an iterative add-shift multiply that takes Bits cycles while busy is high.
//
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-high reset
//   start    request, sampled only while busy=0
//   Control  opcode, captured with start
//   InA      operand A, captured with start
//   InB      operand B / shift amount, captured with start
//   Result   registered result of the last completed op
//   Flags    registered flags {N, Z, C, V}
//   busy     high while a multiply is in progress
//   done     one-cycle pulse when Result/Flags update
module alu_seq #(
    parameter int Bits = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      Control,
    input  logic [Bits-1:0] InA,
    input  logic [Bits-1:0] InB,
    output logic [Bits-1:0] Result,
    output logic [3:0]      Flags,
    output logic            busy,
    output logic            done
);

    typedef enum logic {IDLE, MUL} state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SRA = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    // At least one counter bit so Bits=2 still counts 0..1.
    localparam int CW = (Bits > 2) ? $clog2(Bits) : 1;

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [2*Bits-1:0]  mcand, mcand_n;
    logic [Bits-1:0]    mplier, mplier_n;
    logic [2*Bits-1:0]  acc, acc_n;
    logic [2*Bits-1:0]  acc_step;
    logic [Bits-1:0]    result_n;
    logic [3:0]         flags_n;
    logic               done_n;

    op_t                op;
    logic [Bits:0]      add_w, sub_w;
    logic [Bits:0]      shl_w, sra_w;
    logic               big_amt;
    logic [Bits-1:0]    alu_res;
    logic               alu_c, alu_v;

    assign op      = op_t'(Control);
    assign add_w   = {1'b0, InA} + {1'b0, InB};
    assign sub_w   = {1'b0, InA} + {1'b0, ~InB} + (Bits+1)'(1);
    assign big_amt = (InB >= Bits'(Bits));
    // One guard bit beside the operand catches the last bit shifted out.
    assign shl_w   = {1'b0, InA} << InB;
    assign sra_w   = $signed({InA, 1'b0}) >>> InB;
    assign acc_step = acc + (mplier[0] ? mcand : '0);
    assign busy    = (state == MUL);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = add_w[Bits-1:0];
                alu_c   = add_w[Bits];
                alu_v   = (InA[Bits-1] == InB[Bits-1]) && (add_w[Bits-1] != InA[Bits-1]);
            end
            OP_SUB: begin
                alu_res = sub_w[Bits-1:0];
                alu_c   = sub_w[Bits];
                alu_v   = (InA[Bits-1] != InB[Bits-1]) && (sub_w[Bits-1] != InA[Bits-1]);
            end
            OP_AND: alu_res = InA & InB;
            OP_OR:  alu_res = InA | InB;
            OP_XOR: alu_res = InA ^ InB;
            OP_SHL: begin
                if (big_amt) begin
                    alu_res = '0;
                end else begin
                    alu_res = shl_w[Bits-1:0];
                    alu_c   = shl_w[Bits];
                end
            end
            OP_SRA: begin
                if (big_amt) begin
                    alu_res = {Bits{InA[Bits-1]}};
                end else begin
                    alu_res = sra_w[Bits:1];
                    alu_c   = sra_w[0];
                end
            end
            default: begin
                alu_res = '0;
            end
        endcase
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        mcand_n  = mcand;
        mplier_n = mplier;
        acc_n    = acc;
        result_n = Result;
        flags_n  = Flags;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mcand_n  = {{Bits{1'b0}}, InA};
                        mplier_n = InB;
                        acc_n    = '0;
                        cnt_n    = '0;
                        state_n  = MUL;
                    end else begin
                        result_n = alu_res;
                        flags_n  = {alu_res[Bits-1], (alu_res == '0), alu_c, alu_v};
                        done_n   = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_n    = acc_step;
                mcand_n  = mcand << 1;
                mplier_n = mplier >> 1;
                if (cnt == CW'(Bits-1)) begin
                    // Last step: commit the just-formed product, not the stale accumulator.
                    result_n = acc_step[Bits-1:0];
                    flags_n  = {acc_step[Bits-1], (acc_step[Bits-1:0] == '0),
                                (|acc_step[2*Bits-1:Bits]), 1'b0};
                    done_n   = 1'b1;
                    cnt_n    = '0;
                    state_n  = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            Result <= '0;
            Flags  <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            mcand  <= mcand_n;
            mplier <= mplier_n;
            acc    <= acc_n;
            Result <= result_n;
            Flags  <= flags_n;
            done   <= done_n;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (Bits=5): reset, add/sub, logic/shift,
// multiply, abort and back-to-back issue, checked through an expected-result queue.
module tb_alu_seq;

    localparam int W = 5;

    logic         clk, rst, start;
    logic [2:0]   Control;
    logic [W-1:0] InA, InB, Result;
    logic [3:0]   Flags;
    logic         busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0] res;
        logic [3:0] flg;
    } exp_t;

    typedef struct packed {
        logic [2:0] op;
        logic [4:0] a;
        logic [4:0] b;
        logic [4:0] res;
        logic [3:0] flg;
    } vec_t;

    exp_t sb[$];

    alu_seq #(.Bits(W)) dut (
        .clk(clk), .rst(rst), .start(start), .Control(Control),
        .InA(InA), .InB(InB), .Result(Result), .Flags(Flags),
        .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start   = 1'($urandom_range(0, 1));
            Control = 3'($urandom);
            InA     = 5'($urandom);
            InB     = 5'($urandom);
            #1;
            checks++;
            if ({Result, Flags, busy, done} !== 11'b0) begin
                errors++;
                $display("FAIL reset_hold: got R=%b F=%b busy=%b done=%b want all 0",
                         Result, Flags, busy, done);
            end
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({Result, Flags, busy, done} !== 11'b0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got R=%b F=%b busy=%b done=%b want all 0",
                         i, Result, Flags, busy, done);
            end
        end
    endtask

    task automatic test_addsub;
        vec_t v[5];
        exp_t e;
        v[0] = {3'b000, 5'd12,      5'd7,       5'd19,      4'b1001};
        v[1] = {3'b001, 5'd5,       5'd5,       5'd0,       4'b0110};
        v[2] = {3'b001, 5'd3,       5'd4,       5'd31,      4'b1000};
        v[3] = {3'b000, 5'd31,      5'd1,       5'd0,       4'b0110};
        v[4] = {3'b001, 5'b10000,   5'd1,       5'b01111,   4'b0011};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b1; Control = v[i].op; InA = v[i].a; InB = v[i].b;
            sb.push_back({v[i].res, v[i].flg});
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL addsub[%0d] done_latency: got %b want 1", i, done);
            end
            e = sb.pop_front();
            checks++;
            if (Result !== e.res) begin
                errors++;
                $display("FAIL addsub[%0d] result: got %b want %b", i, Result, e.res);
            end
            checks++;
            if (Flags !== e.flg) begin
                errors++;
                $display("FAIL addsub[%0d] flags: got %b want %b", i, Flags, e.flg);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL addsub[%0d] done_pulse: got %b want 0", i, done);
            end
        end
    endtask

    task automatic test_logic_shift;
        vec_t v[12];
        exp_t e;
        v[0]  = {3'b010, 5'b10110, 5'b01111, 5'b00110, 4'b0000};
        v[1]  = {3'b011, 5'b10100, 5'b00011, 5'b10111, 4'b1000};
        v[2]  = {3'b100, 5'b10101, 5'b10101, 5'b00000, 4'b0100};
        v[3]  = {3'b101, 5'b00011, 5'd3,     5'b11000, 4'b1000};
        v[4]  = {3'b110, 5'b10000, 5'd2,     5'b11100, 4'b1000};
        v[5]  = {3'b110, 5'b10001, 5'd1,     5'b11000, 4'b1010};
        v[6]  = {3'b101, 5'b00011, 5'd7,     5'b00000, 4'b0100};
        v[7]  = {3'b101, 5'b11000, 5'd2,     5'b00000, 4'b0110};
        v[8]  = {3'b101, 5'b10101, 5'd0,     5'b10101, 4'b1000};
        v[9]  = {3'b110, 5'b10101, 5'd5,     5'b11111, 4'b1000};
        v[10] = {3'b110, 5'b01111, 5'd4,     5'b00000, 4'b0110};
        v[11] = {3'b101, 5'b00001, 5'd4,     5'b10000, 4'b1000};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start = 1'b1; Control = v[i].op; InA = v[i].a; InB = v[i].b;
            sb.push_back({v[i].res, v[i].flg});
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL logic_shift[%0d] done: got %b want 1", i, done);
            end
            e = sb.pop_front();
            checks++;
            if (Result !== e.res) begin
                errors++;
                $display("FAIL logic_shift[%0d] result: got %b want %b", i, Result, e.res);
            end
            checks++;
            if (Flags !== e.flg) begin
                errors++;
                $display("FAIL logic_shift[%0d] flags: got %b want %b", i, Flags, e.flg);
            end
        end
    endtask

    task automatic test_mul;
        vec_t v[4];
        exp_t e;
        int n;
        v[0] = {3'b111, 5'd7,  5'd5,  5'd3,  4'b0010};
        v[1] = {3'b111, 5'd3,  5'd4,  5'd12, 4'b0000};
        v[2] = {3'b111, 5'd6,  5'd5,  5'd30, 4'b1000};
        v[3] = {3'b111, 5'd31, 5'd31, 5'd1,  4'b0010};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b1; Control = v[i].op; InA = v[i].a; InB = v[i].b;
            sb.push_back({v[i].res, v[i].flg});
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL mul[%0d] accept: got busy=%b done=%b want busy=1 done=0", i, busy, done);
            end
            n = 0;
            while (done !== 1'b1 && n < 20) begin
                @(posedge clk); #1;
                n++;
                if (i == 0 && n == 2) begin
                    start = 1'b1; Control = 3'b000; InA = 5'd1; InB = 5'd1;
                end
                if (i == 0 && n == 3) start = 1'b0;
                if (done !== 1'b1) begin
                    checks++;
                    if (busy !== 1'b1) begin
                        errors++;
                        $display("FAIL mul[%0d] busy_hold cycle %0d: got %b want 1", i, n, busy);
                    end
                end
            end
            start = 1'b0;
            checks++;
            if (n != W) begin
                errors++;
                $display("FAIL mul[%0d] latency: got %0d want %0d", i, n, W);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL mul[%0d] busy_drop: got %b want 0", i, busy);
            end
            e = sb.pop_front();
            checks++;
            if (Result !== e.res) begin
                errors++;
                $display("FAIL mul[%0d] result: got %b want %b", i, Result, e.res);
            end
            checks++;
            if (Flags !== e.flg) begin
                errors++;
                $display("FAIL mul[%0d] flags: got %b want %b", i, Flags, e.flg);
            end
            for (int j = 0; j < 3; j++) begin
                @(posedge clk); #1;
                checks++;
                if (done !== 1'b0 || Result !== e.res) begin
                    errors++;
                    $display("FAIL mul[%0d] quiet[%0d]: got done=%b R=%b want done=0 R=%b",
                             i, j, done, Result, e.res);
                end
            end
        end
    endtask

    task automatic test_abort;
        exp_t e;
        int seen;
        @(negedge clk);
        start = 1'b1; Control = 3'b111; InA = 5'd31; InB = 5'd31;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({Result, Flags, busy, done} !== 11'b0) begin
            errors++;
            $display("FAIL abort_async: got R=%b F=%b busy=%b done=%b want all 0",
                     Result, Flags, busy, done);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d active cycles want 0", seen);
        end
        @(negedge clk);
        start = 1'b1; Control = 3'b000; InA = 5'd1; InB = 5'd1;
        sb.push_back({5'd2, 4'b0000});
        @(posedge clk); #1;
        start = 1'b0;
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || Result !== e.res || Flags !== e.flg) begin
            errors++;
            $display("FAIL abort_recover: got done=%b R=%b F=%b want done=1 R=%b F=%b",
                     done, Result, Flags, e.res, e.flg);
        end
    endtask

    task automatic test_back_to_back;
        vec_t v[3];
        exp_t e;
        v[0] = {3'b100, 5'b10101, 5'b01100, 5'b11001, 4'b1000};
        v[1] = {3'b011, 5'b00001, 5'b00010, 5'b00011, 4'b0000};
        v[2] = {3'b000, 5'b01111, 5'b00001, 5'b10000, 4'b1001};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b1; Control = v[i].op; InA = v[i].a; InB = v[i].b;
            sb.push_back({v[i].res, v[i].flg});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (done !== 1'b1 || Result !== e.res || Flags !== e.flg) begin
                errors++;
                $display("FAIL b2b[%0d]: got done=%b R=%b F=%b want done=1 R=%b F=%b",
                         i, done, Result, Flags, e.res, e.flg);
            end
        end
        @(negedge clk);
        start = 1'b0; Control = 3'b010; InA = 5'b00000; InB = 5'b11111;
        for (int j = 0; j < 2; j++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || Result !== 5'b10000 || Flags !== 4'b1001) begin
                errors++;
                $display("FAIL b2b_hold[%0d]: got done=%b R=%b F=%b want done=0 R=10000 F=1001",
                         j, done, Result, Flags);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; Control = '0; InA = '0; InB = '0;
        test_reset();
        test_addsub();
        test_logic_shift();
        test_mul();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
